// File: rtl/psec6_readout_shifter_if.sv
// Bundle for the readout shifter: host-side frame controls, counter bank input
// and the serial readout / status outputs.
interface psec6_readout_shifter_if #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 12
);
    logic                      cs;
    logic                      inst_readout;
    logic [2:0]                select_reg;
    logic [NUM_CH*CNT_W-1:0]   ch_data;
    logic                      poci_readout;
    logic                      readout_busy;
    logic                      readout_done;
    logic                      overrun;

    modport master (
        output cs, inst_readout, select_reg, ch_data,
        input  poci_readout, readout_busy, readout_done, overrun
    );

    modport slave (
        input  cs, inst_readout, select_reg, ch_data,
        output poci_readout, readout_busy, readout_done, overrun
    );
endinterface

// File: rtl/psec6_readout_shifter.sv
// Snapshots the channel counter bank on a readout instruction and shifts it out
// MSB-first behind a 4-bit header. Optional per-word parity: READOUT_PARITY_EN.
module psec6_readout_shifter #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 12
) (
    input  logic                     spi_clk,
    input  logic                     rstn,
    psec6_readout_shifter_if.slave   bus
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DATA_W = NUM_CH * CNT_W;
`ifdef READOUT_PARITY_EN
    localparam int BIT_W    = $clog2(CNT_W + 1);
    localparam int LAST_BIT = CNT_W;
`else
    localparam int BIT_W    = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam int LAST_BIT = CNT_W - 1;
`endif
    localparam logic [CH_W-1:0]  LAST_CH_V  = CH_W'(NUM_CH - 1);
    localparam logic [BIT_W-1:0] LAST_BIT_V = BIT_W'(LAST_BIT);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                sync3_q, sync3_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [3:0]          hdr_q, hdr_d;
    logic [1:0]          hdr_cnt_q, hdr_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
    logic                hdr_phase_q, hdr_phase_d;
    logic                poci_q, poci_d;
    logic                overrun_q, overrun_d;

    logic                req;
    logic                last_bit;
    logic                nxt_hdr_phase;
    logic [1:0]          nxt_hdr_cnt;
    logic [BIT_W-1:0]    nxt_bit;
    logic [CH_W-1:0]     nxt_ch;
    logic [CNT_W-1:0]    nxt_word;
    logic                nxt_data_bit;
    logic                nxt_poci;

    logic [CNT_W-1:0]    word_arr [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_word
            assign word_arr[gi] = data_q[gi*CNT_W +: CNT_W];
        end
    endgenerate

`ifdef READOUT_PARITY_EN
    logic                word_par [NUM_CH];
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_par
            assign word_par[gi] = ^word_arr[gi];
        end
    endgenerate
`endif

    assign req = sync2_q & ~sync3_q;

    // Counters always describe the bit currently on poci; this works out the
    // position (and value) of the bit that the next advancing edge will show.
    always_comb begin
        nxt_hdr_phase = hdr_phase_q;
        nxt_hdr_cnt   = hdr_cnt_q;
        nxt_bit       = bit_cnt_q;
        nxt_ch        = ch_cnt_q;
        last_bit      = !hdr_phase_q && (ch_cnt_q == LAST_CH_V) && (bit_cnt_q == LAST_BIT_V);
        if (hdr_phase_q) begin
            if (hdr_cnt_q == 2'd3) begin
                nxt_hdr_phase = 1'b0;
                nxt_bit       = '0;
                nxt_ch        = '0;
            end else begin
                nxt_hdr_cnt = hdr_cnt_q + 2'd1;
            end
        end else if (bit_cnt_q == LAST_BIT_V) begin
            nxt_bit = '0;
            nxt_ch  = ch_cnt_q + 1'b1;
        end else begin
            nxt_bit = bit_cnt_q + 1'b1;
        end

        nxt_word     = word_arr[nxt_ch];
        nxt_data_bit = 1'b0;
        for (int j = 0; j < CNT_W; j++) begin
            if (nxt_bit == BIT_W'(CNT_W - 1 - j)) nxt_data_bit = nxt_word[j];
        end
`ifdef READOUT_PARITY_EN
        if (nxt_bit == BIT_W'(CNT_W)) nxt_data_bit = word_par[nxt_ch];
`endif
        nxt_poci = nxt_hdr_phase ? hdr_q[~nxt_hdr_cnt] : nxt_data_bit;
    end

    always_comb begin
        state_d     = state_q;
        sync1_d     = bus.inst_readout;
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;
        data_d      = data_q;
        hdr_d       = hdr_q;
        hdr_cnt_d   = hdr_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        ch_cnt_d    = ch_cnt_q;
        hdr_phase_d = hdr_phase_q;
        poci_d      = poci_q;
        overrun_d   = overrun_q;

        case (state_q)
            ST_IDLE: begin
                poci_d = 1'b0;
                if (req) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                data_d      = bus.ch_data;
                hdr_d       = {1'b1, bus.select_reg};
                hdr_cnt_d   = '0;
                bit_cnt_d   = '0;
                ch_cnt_d    = '0;
                hdr_phase_d = 1'b1;
                // Header MSB is always 1, so bit 0 is ready as SHIFT begins.
                poci_d      = 1'b1;
                overrun_d   = req;
                state_d     = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (req) overrun_d = 1'b1;
                if (!bus.cs) begin
                    if (last_bit) begin
                        poci_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        hdr_phase_d = nxt_hdr_phase;
                        hdr_cnt_d   = nxt_hdr_cnt;
                        bit_cnt_d   = nxt_bit;
                        ch_cnt_d    = nxt_ch;
                        poci_d      = nxt_poci;
                    end
                end
            end
            ST_DONE: begin
                if (req) overrun_d = 1'b1;
                poci_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                poci_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            data_q      <= '0;
            hdr_q       <= '0;
            hdr_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            ch_cnt_q    <= '0;
            hdr_phase_q <= 1'b0;
            poci_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            data_q      <= data_d;
            hdr_q       <= hdr_d;
            hdr_cnt_q   <= hdr_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            ch_cnt_q    <= ch_cnt_d;
            hdr_phase_q <= hdr_phase_d;
            poci_q      <= poci_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.poci_readout = poci_q;
    assign bus.readout_busy = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    assign bus.readout_done = (state_q == ST_DONE);
    assign bus.overrun      = overrun_q;
endmodule

// File: doc/psec6_readout_shifter.md
Name: psec6_readout_shifter

Overview:
- Downstream consumer of the SPI block's `inst_readout` and `select_reg` outputs.
- On a readout instruction, snapshots the counter bank selected in the channel digital, then serializes it MSB-first onto `poci_readout`.
- `poci_readout` is muxed with `poci_spi` at the readout mux. The shifter advances on `spi_clk` only while the host holds the frame open (`cs` low).

Parameters:
- NUM_CH, 8, number of channels serialized per frame.
- CNT_W, 12, width of each channel counter word.

Ports:
- spi_clk  input  1  sole clock; all state updates on rising edge.
- rstn  input  1  chip-wide reset, asynchronous, active-low.
- cs  input  1  SPI chip select; low = frame active, high = shifting paused.
- inst_readout  input  1  readout instruction level/pulse; asynchronous to spi_clk.
- select_reg  input  3  counter bank currently selected in channel digital.
- ch_data  input  NUM_CH*CNT_W  counter values; channel 0 in bits [CNT_W-1:0].
- poci_readout  output  1  serial readout data.
- readout_busy  output  1  high from LOAD through end of SHIFT.
- readout_done  output  1  one-cycle pulse at frame end.
- overrun  output  1  sticky: a request arrived while busy.

Behaviour:
- Reset (rstn=0, async): state=IDLE, all counters 0, snapshot 0. Outputs `poci_readout`, `readout_busy`, `readout_done` and `overrun` are all 0.
- inst_readout synchronization:
  - Passed through a 2-flop synchronizer, then rising-edge detected.
  - `req` = synced & ~synced_d.
  - A level held high produces exactly one `req`.
- FSM states IDLE, LOAD, SHIFT, DONE:
  - IDLE: on `req` -> LOAD. `cs` is ignored in IDLE.
  - LOAD (1 cycle, unconditional):
    - Snapshot `ch_data` into a shift buffer.
    - Latch hdr = {1'b1, select_reg}.
    - Clear `bit_cnt`, `ch_cnt`, `overrun`.
    - Next state SHIFT.
  - SHIFT: one bit per spi_clk while cs=0. While cs=1, all counters and outputs hold (pause, not abort).
  - Bit order:
    - 4 header bits, MSB first.
    - Then channel 0 word MSB first, channel 1, ..., channel NUM_CH-1.
  - Frame length F = 4 + NUM_CH*CNT_W = 100 bits by default.
  - After the last bit is driven -> DONE.
  - DONE (1 cycle): `readout_done`=1 -> IDLE.
- Output timing:
  - `poci_readout` is registered; bit k appears the cycle after the k-th advancing SHIFT edge.
  - `poci_readout`=0 whenever not in SHIFT.
  - First header bit (1) is visible on the first SHIFT cycle.
- `readout_busy` = state in {LOAD, SHIFT}; it is 0 in DONE.
- Counter rules:
  - `bit_cnt` width is clog2(CNT_W); it wraps to 0 at CNT_W-1 and increments `ch_cnt`.
  - The header uses a separate 2-bit counter.
  - The frame ends when `ch_cnt`==NUM_CH-1 and `bit_cnt`==CNT_W-1, with cs=0.
- Simultaneous and boundary events:
  - `req` during LOAD, SHIFT or DONE: request dropped, `overrun`=1.
  - `overrun` stays 1 until the next LOAD.
  - `req` in the same cycle DONE->IDLE: dropped (counts as overrun).
  - `ch_data` changes after LOAD: no effect on the frame in flight.
  - `select_reg` changes after LOAD: no effect on the frame in flight.
  - rstn asserted mid-frame: immediate abort to reset values; no `readout_done`.

Optional Feature:
- Macro READOUT_PARITY_EN.
- Defined:
  - Each channel word is followed by 1 even-parity bit (XOR of that word's CNT_W bits).
  - F = 4 + NUM_CH*(CNT_W+1) = 108.
  - `bit_cnt` wraps at CNT_W.
- Undefined: no parity bits, F = 100; the parity logic is not present.

Test Plan:
- Frame contents: reset, then ch_data = {12'h807, ..., 12'h001} (ch i = i+1, ch7 = 12'h807), select_reg=3'd5, pulse inst_readout with cs=0.
  - Header 1101 appears, then 000000000001, ..., 100000000111.
  - `readout_done` pulses exactly 1 cycle after the 100th bit; `readout_busy` is 0 afterwards.
- Pause: same as above, but drive cs=1 for 7 cycles after bit 20.
  - `poci_readout` holds bit 20's value for those 7 cycles.
  - Frame resumes at bit 21; the bitstream is identical to the no-pause case.
- Overrun: second inst_readout rising edge at bit 50.
  - `overrun`=1 and stays 1; the frame is uncorrupted; no second frame starts.
  - A later request starts a new frame and clears `overrun` in LOAD.
- Snapshot isolation: change ch_data to all 12'hFFF and select_reg to 0 during SHIFT.
  - Output still matches the values captured at LOAD.
- Reset mid-frame: assert rstn=0 at bit 37.
  - All outputs are 0 immediately (async), with no `readout_done`.
  - After release, a new request yields a full 100-bit frame.
- Parity (READOUT_PARITY_EN defined): ch0=12'h003, ch1=12'h007.
  - Parity bits are 0 and 1 respectively; frame length is 108 bits.
